boot_copy_ctrl: RTL and testbench

- Sits on the instruction path between the MMU's instruction bus port and the system interconnect.
- After reset it owns the bus and copies a boot image of BOOT_WORDS 32-bit words from flash (FLASH_BASE) to instruction RAM (RAM_BASE) using the bus handshake; during this the CPU side sees no ready.
- Once the copy completes it becomes a transparent pass-through: CPU-side handshake connects straight to the bus.

---
 rtl/mero_pkg.sv | 29 ++
 rtl/boot_copy_ctrl_if.sv | 38 +++
 rtl/boot_copy_ctrl.sv | 124 ++++++++++++
 tb/tb_boot_copy_ctrl.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mero_pkg.sv
// Shared definitions for the boot-copy controller and its neighbours.
//
// Contents:
//   boot_state_e    - controller state encoding (COPY_RD=0, COPY_WR=1, GAP=2, RUN=3)
//   MAP_FLASH_BASE  - default byte address of the boot image in flash
//   MAP_RAM_BASE    - default byte address of instruction RAM
//   word_addr()     - byte address of word <idx> in a region starting at <base>
//
// The memory-map constants are also used by the interconnect address decoder,
// so they live here rather than inside the controller.
package mero_pkg;

   typedef enum logic [1:0] {
      COPY_RD = 2'd0,
      COPY_WR = 2'd1,
      GAP     = 2'd2,
      RUN     = 2'd3
   } boot_state_e;

   localparam logic [31:0] MAP_FLASH_BASE = 32'h2000_0000;
   localparam logic [31:0] MAP_RAM_BASE   = 32'h0000_0000;

   // Plain 32-bit arithmetic: a region that runs past 2^32 wraps silently.
   function automatic logic [31:0] word_addr(input logic [31:0] base,
                                             input logic [31:0] idx);
      return base + (idx << 2);
   endfunction

endpackage

// File: rtl/boot_copy_ctrl_if.sv
// Request/complete handshake used on both sides of the boot-copy controller
// (MMU instruction port and system interconnect).
//
// Signals:
//   rd, wr  - request strobes from the master; never both high
//   addr    - byte address of the request
//   wdata   - write data
//   ready   - one-cycle completion pulse from the slave
//   rdata   - read data, meaningful only in the cycle ready=1
//
// Handshake: the master raises rd or wr together with addr/wdata and holds all
// of them stable until it sees ready=1 for one cycle; the transfer completes on
// the clock edge that samples ready=1, and a new request may start in the next
// cycle. There is no separate acceptance phase.
//
// Modports:
//   master - drives the request, receives ready/rdata
//   slave  - receives the request, drives ready/rdata
interface boot_copy_ctrl_if;

   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic [31:0] rdata;

   modport master (
      output rd, wr, addr, wdata,
      input  ready, rdata
   );

   modport slave (
      input  rd, wr, addr, wdata,
      output ready, rdata
   );

endinterface

// File: rtl/boot_copy_ctrl.sv
// Boot-copy controller on the instruction path between the MMU and the
// interconnect. Out of reset it masters the bus and copies BOOT_WORDS words
// from FLASH_BASE to RAM_BASE (read, write, one idle cycle, repeat). While the
// copy runs the CPU side sees no ready. When the last word is written it
// becomes a purely combinational pass-through and stays that way until reset.
//
// Ports:
//   clk_i        - system clock
//   rst_i        - asynchronous active-low reset
//   cpu_hs       - slave side, requests from the MMU instruction port
//   bus_hs       - master side, requests to the interconnect
//   boot_done_o  - registered, high from the first cycle in RUN
//   state_o      - current controller state (observability)
module boot_copy_ctrl
   import mero_pkg::*;
#(
   parameter logic [31:0] FLASH_BASE = MAP_FLASH_BASE,
   parameter logic [31:0] RAM_BASE   = MAP_RAM_BASE,
   parameter int unsigned BOOT_WORDS = 1024
) (
   input  logic             clk_i,
   input  logic             rst_i,
   boot_copy_ctrl_if.slave  cpu_hs,
   boot_copy_ctrl_if.master bus_hs,
   output logic             boot_done_o,
   output boot_state_e      state_o
);

   // Counter holds 0..BOOT_WORDS; keep at least one bit for the empty image.
   localparam int CW = (BOOT_WORDS < 1) ? 1 : $clog2(BOOT_WORDS + 1);
   localparam logic [CW-1:0] LAST_IDX = (BOOT_WORDS < 1) ? '0 : CW'(BOOT_WORDS - 1);
   localparam boot_state_e RESET_STATE = (BOOT_WORDS == 0) ? RUN : COPY_RD;
   localparam logic DONE_AT_RESET = (BOOT_WORDS == 0);

   boot_state_e   state_r, state_nx;
   logic [CW-1:0] cnt_r, cnt_nx;
   logic [31:0]   word_r, word_nx;
   logic          done_r;

   // Ungated outputs; the reset gate is applied at the ports below.
   logic          rd_c, wr_c;
   logic [31:0]   addr_c, wdata_c;
   logic          cpu_ready_c;
   logic [31:0]   cpu_rdata_c;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r <= RESET_STATE;
         cnt_r   <= '0;
         word_r  <= '0;
         done_r  <= DONE_AT_RESET;
      end else begin
         state_r <= state_nx;
         cnt_r   <= cnt_nx;
         word_r  <= word_nx;
         // RUN is terminal, so done tracks the state being entered.
         done_r  <= (state_nx == RUN);
      end
   end

   always_comb begin
      state_nx    = state_r;
      cnt_nx      = cnt_r;
      word_nx     = word_r;
      rd_c        = 1'b0;
      wr_c        = 1'b0;
      addr_c      = '0;
      wdata_c     = '0;
      cpu_ready_c = 1'b0;
      cpu_rdata_c = '0;

      case (state_r)
         COPY_RD: begin
            rd_c   = 1'b1;
            addr_c = word_addr(FLASH_BASE, 32'(cnt_r));
            if (bus_hs.ready) begin
               word_nx  = bus_hs.rdata;
               state_nx = COPY_WR;
            end
         end

         COPY_WR: begin
            wr_c    = 1'b1;
            addr_c  = word_addr(RAM_BASE, 32'(cnt_r));
            wdata_c = word_r;
            if (bus_hs.ready) begin
               cnt_nx   = cnt_r + CW'(1);
               state_nx = (cnt_r == LAST_IDX) ? RUN : GAP;
            end
         end

         // Mandatory idle cycle between words; a ready seen here is dropped.
         GAP: begin
            state_nx = COPY_RD;
         end

         RUN: begin
            rd_c        = cpu_hs.rd;
            wr_c        = cpu_hs.wr;
            addr_c      = cpu_hs.addr;
            wdata_c     = cpu_hs.wdata;
            cpu_ready_c = bus_hs.ready;
            cpu_rdata_c = bus_hs.rdata;
         end

         default: begin
            state_nx = RESET_STATE;
         end
      endcase
   end

   // While reset is held everything is forced low, including the pass-through
   // path of an image-less build that already sits in RUN.
   assign bus_hs.rd    = rst_i & rd_c;
   assign bus_hs.wr    = rst_i & wr_c;
   assign bus_hs.addr  = rst_i ? addr_c : '0;
   assign bus_hs.wdata = rst_i ? wdata_c : '0;
   assign cpu_hs.ready = rst_i & cpu_ready_c;
   assign cpu_hs.rdata = rst_i ? cpu_rdata_c : '0;

   assign boot_done_o  = done_r;
   assign state_o      = state_r;

endmodule

// File: tb/tb_boot_copy_ctrl.sv
// Bench for boot_copy_ctrl. Three instances: A (4 words, 2-cycle memory),
// B (2 words, single-cycle memory), C (no boot image). A shared memory
// responder acts on the falling clock edge; checks sample 3 ns after it.
module tb_boot_copy_ctrl;
   import mero_pkg::*;

   localparam logic [31:0] FB = 32'h2000_0000;
   localparam logic [31:0] RB = 32'h0000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n   [3];
   logic        c_rd    [3];
   logic        c_wr    [3];
   logic [31:0] c_addr  [3];
   logic [31:0] c_wdata [3];
   logic        c_ready [3];
   logic [31:0] c_rdata [3];
   logic        b_rd    [3];
   logic        b_wr    [3];
   logic [31:0] b_addr  [3];
   logic [31:0] b_wdata [3];
   logic        b_ready [3];
   logic [31:0] b_rdata [3];
   logic        done    [3];
   boot_state_e st      [3];

   boot_copy_ctrl_if cpu_if [3] ();
   boot_copy_ctrl_if bus_if [3] ();

   for (genvar g = 0; g < 3; g++) begin : g_wire
      assign cpu_if[g].rd    = c_rd[g];
      assign cpu_if[g].wr    = c_wr[g];
      assign cpu_if[g].addr  = c_addr[g];
      assign cpu_if[g].wdata = c_wdata[g];
      assign c_ready[g]      = cpu_if[g].ready;
      assign c_rdata[g]      = cpu_if[g].rdata;
      assign b_rd[g]         = bus_if[g].rd;
      assign b_wr[g]         = bus_if[g].wr;
      assign b_addr[g]       = bus_if[g].addr;
      assign b_wdata[g]      = bus_if[g].wdata;
      assign bus_if[g].ready = b_ready[g];
      assign bus_if[g].rdata = b_rdata[g];
   end

   boot_copy_ctrl #(.FLASH_BASE(FB), .RAM_BASE(RB), .BOOT_WORDS(4)) dut_a (
      .clk_i(clk), .rst_i(rst_n[0]), .cpu_hs(cpu_if[0]), .bus_hs(bus_if[0]),
      .boot_done_o(done[0]), .state_o(st[0]));
   boot_copy_ctrl #(.FLASH_BASE(FB), .RAM_BASE(RB), .BOOT_WORDS(2)) dut_b (
      .clk_i(clk), .rst_i(rst_n[1]), .cpu_hs(cpu_if[1]), .bus_hs(bus_if[1]),
      .boot_done_o(done[1]), .state_o(st[1]));
   boot_copy_ctrl #(.FLASH_BASE(FB), .RAM_BASE(RB), .BOOT_WORDS(0)) dut_c (
      .clk_i(clk), .rst_i(rst_n[2]), .cpu_hs(cpu_if[2]), .bus_hs(bus_if[2]),
      .boot_done_o(done[2]), .state_o(st[2]));

   int total = 0;
   int bad   = 0;

   // Memory model: 8 words of flash and 8 words of RAM per instance.
   logic [31:0] flash [3][8];
   logic [31:0] ram   [3][8];
   int          lat    [3];
   bit          inject [3];
   int          inj_n  [3];
   int          wcnt   [3];
   bit          log_wr   [3][32];
   logic [31:0] log_addr [3][32];
   logic [31:0] log_data [3][32];
   int          log_n    [3];

   function automatic logic [31:0] mem_rd(input int k, input logic [31:0] a);
      if (a[31:28] == 4'h2) return flash[k][a[4:2]];
      return ram[k][a[4:2]];
   endfunction

   // Responder: counts request cycles, pulses ready after lat[k] of them,
   // logs each completed transfer; optionally pulses a stray ready whenever
   // the bus is idle before boot is done (that is only the GAP cycle).
   initial begin
      for (int k = 0; k < 3; k++) begin
         b_ready[k] = 1'b0; b_rdata[k] = '0; wcnt[k] = 0; inj_n[k] = 0; log_n[k] = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (!rst_n[k]) begin
               b_ready[k] = 1'b0;
               wcnt[k]    = 0;
            end else begin
               if (b_ready[k]) begin
                  b_ready[k] = 1'b0;
                  wcnt[k]    = 0;
               end
               if (b_rd[k] || b_wr[k]) begin
                  wcnt[k]++;
                  if (wcnt[k] >= lat[k]) begin
                     b_ready[k] = 1'b1;
                     if (b_rd[k]) b_rdata[k] = mem_rd(k, b_addr[k]);
                     else begin
                        b_rdata[k] = $urandom;
                        if (b_addr[k][31:28] == 4'h2) flash[k][b_addr[k][4:2]] = b_wdata[k];
                        else ram[k][b_addr[k][4:2]] = b_wdata[k];
                     end
                     if (log_n[k] < 32) begin
                        log_wr[k][log_n[k]]   = b_wr[k];
                        log_addr[k][log_n[k]] = b_addr[k];
                        log_data[k][log_n[k]] = b_wr[k] ? b_wdata[k] : b_rdata[k];
                        log_n[k]++;
                     end
                  end
               end else begin
                  wcnt[k] = 0;
                  if (inject[k] && !done[k]) begin
                     b_ready[k] = 1'b1;
                     b_rdata[k] = $urandom;
                     inj_n[k]++;
                  end
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(negedge clk);
      #3;
   endtask

   task automatic release_rst(input int k);
      @(posedge clk);
      #1 rst_n[k] = 1'b1;
   endtask

   task automatic test_reset;
      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
         total++;
         if (b_rd[k] !== 1'b0 || b_wr[k] !== 1'b0) begin
            bad++; $display("FAIL reset_bus_req[%0d]: rd=%b wr=%b want 0 0", k, b_rd[k], b_wr[k]);
         end
         total++;
         if (b_addr[k] !== 32'h0 || b_wdata[k] !== 32'h0) begin
            bad++; $display("FAIL reset_bus_addr[%0d]: addr=%h data=%h want 0", k, b_addr[k], b_wdata[k]);
         end
         total++;
         if (c_ready[k] !== 1'b0 || c_rdata[k] !== 32'h0) begin
            bad++; $display("FAIL reset_cpu[%0d]: ready=%b data=%h want 0", k, c_ready[k], c_rdata[k]);
         end
         total++;
         if (done[k] !== (k == 2)) begin
            bad++; $display("FAIL reset_done[%0d]: got %b want %b", k, done[k], (k == 2));
         end
      end
      // Image-less build sits in RUN; a bus ready must still not reach the CPU.
      b_ready[2] = 1'b1;
      b_rdata[2] = 32'h1234_5678;
      #1;
      total++;
      if (c_ready[2] !== 1'b0 || c_rdata[2] !== 32'h0) begin
         bad++; $display("FAIL reset_gate_c: ready=%b data=%h want 0 0", c_ready[2], c_rdata[2]);
      end
      b_ready[2] = 1'b0;
   endtask

   task automatic test_copy_a;
      bit          exp_wr   [$];
      logic [31:0] exp_addr [$];
      logic [31:0] exp_data [$];
      int cyc, last_wr_cyc, done_cyc;
      bit served;
      for (int i = 0; i < 8; i++) ram[0][i] = '0;
      for (int i = 0; i < 4; i++) flash[0][i] = 32'hA0 + 32'(i);
      for (int i = 0; i < 4; i++) begin
         exp_wr.push_back(1'b0); exp_addr.push_back(FB + 32'(4 * i)); exp_data.push_back(32'hA0 + 32'(i));
         exp_wr.push_back(1'b1); exp_addr.push_back(RB + 32'(4 * i)); exp_data.push_back(32'hA0 + 32'(i));
      end
      exp_wr.push_back(1'b0); exp_addr.push_back(32'h4); exp_data.push_back(32'hA1);
      log_n[0] = 0;
      release_rst(0);
      cyc = 0; last_wr_cyc = -1; done_cyc = -1; served = 1'b0;
      while (!served && cyc < 300) begin
         tick();
         cyc++;
         if (log_n[0] == 8 && last_wr_cyc < 0) last_wr_cyc = cyc;
         if (!done[0]) begin
            total++;
            if (c_ready[0] !== 1'b0 || c_rdata[0] !== 32'h0) begin
               bad++; $display("FAIL copy_cpu_blocked: ready=%b data=%h want 0 0", c_ready[0], c_rdata[0]);
            end
         end else begin
            if (done_cyc < 0) done_cyc = cyc;
            if (b_ready[0]) begin
               total++;
               if (c_ready[0] !== 1'b1 || c_rdata[0] !== b_rdata[0]) begin
                  bad++; $display("FAIL run_zero_latency: ready=%b data=%h want 1 %h", c_ready[0], c_rdata[0], b_rdata[0]);
               end
               total++;
               if (c_rdata[0] !== 32'hA1) begin
                  bad++; $display("FAIL run_cpu_data: got %h want %h", c_rdata[0], 32'hA1);
               end
               served = 1'b1;
               @(posedge clk);
               #1 c_rd[0] = 1'b0;
            end
         end
      end
      total++;
      if (!served) begin
         bad++; $display("FAIL copy_a_timeout: cpu read not served after %0d cycles", cyc);
      end
      total++;
      if (done_cyc !== last_wr_cyc + 1) begin
         bad++; $display("FAIL done_after_last_wr: done at %0d want %0d", done_cyc, last_wr_cyc + 1);
      end
      total++;
      if (log_n[0] !== exp_wr.size()) begin
         bad++; $display("FAIL copy_a_count: got %0d transfers want %0d", log_n[0], exp_wr.size());
      end
      for (int i = 0; i < exp_wr.size() && i < log_n[0]; i++) begin
         total++;
         if (log_wr[0][i] !== exp_wr[i] || log_addr[0][i] !== exp_addr[i] || log_data[0][i] !== exp_data[i]) begin
            bad++; $display("FAIL copy_a_xfer[%0d]: wr=%b addr=%h data=%h want %b %h %h", i,
                            log_wr[0][i], log_addr[0][i], log_data[0][i], exp_wr[i], exp_addr[i], exp_data[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (ram[0][i] !== 32'hA0 + 32'(i)) begin
            bad++; $display("FAIL copy_a_ram[%0d]: got %h want %h", i, ram[0][i], 32'hA0 + 32'(i));
         end
      end
   endtask

   task automatic test_mid_reset;
      int cyc;
      rst_n[0] = 1'b0;
      repeat (2) tick();
      log_n[0] = 0;
      release_rst(0);
      cyc = 0;
      tick();
      while (!(b_wr[0] === 1'b1 && log_n[0] == 3) && cyc < 100) begin
         tick();
         cyc++;
      end
      total++;
      if (cyc >= 100) begin
         bad++; $display("FAIL mid_reset_reach: word 1 write not reached, transfers=%0d", log_n[0]);
      end
      #1 rst_n[0] = 1'b0;
      #1;
      total++;
      if (b_rd[0] !== 1'b0 || b_wr[0] !== 1'b0 || b_addr[0] !== 32'h0 || b_wdata[0] !== 32'h0) begin
         bad++; $display("FAIL mid_reset_bus: rd=%b wr=%b addr=%h data=%h want 0", b_rd[0], b_wr[0], b_addr[0], b_wdata[0]);
      end
      total++;
      if (done[0] !== 1'b0 || c_ready[0] !== 1'b0 || st[0] !== COPY_RD) begin
         bad++; $display("FAIL mid_reset_state: done=%b ready=%b state=%0d want 0 0 0", done[0], c_ready[0], st[0]);
      end
      repeat (2) tick();
      log_n[0] = 0;
      release_rst(0);
      cyc = 0;
      while (log_n[0] < 1 && cyc < 20) begin
         tick();
         cyc++;
      end
      total++;
      if (log_n[0] < 1 || log_wr[0][0] !== 1'b0 || log_addr[0][0] !== FB) begin
         bad++; $display("FAIL mid_reset_restart: n=%0d wr=%b addr=%h want rd at %h", log_n[0], log_wr[0][0], log_addr[0][0], FB);
      end
   endtask

   task automatic test_gap_ready;
      int cyc;
      rst_n[0] = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) ram[0][i] = '0;
      for (int i = 0; i < 4; i++) flash[0][i] = $urandom;
      log_n[0] = 0; inj_n[0] = 0; inject[0] = 1'b1;
      release_rst(0);
      cyc = 0;
      while (done[0] !== 1'b1 && cyc < 300) begin
         tick();
         cyc++;
      end
      inject[0] = 1'b0;
      repeat (2) tick();
      total++;
      if (done[0] !== 1'b1) begin
         bad++; $display("FAIL gap_timeout: done=%b after %0d cycles", done[0], cyc);
      end
      total++;
      if (inj_n[0] !== 3) begin
         bad++; $display("FAIL gap_pulses: got %0d stray pulses want 3", inj_n[0]);
      end
      total++;
      if (log_n[0] !== 8) begin
         bad++; $display("FAIL gap_count: got %0d transfers want 8", log_n[0]);
      end
      for (int i = 0; i < 8 && i < log_n[0]; i++) begin
         logic [31:0] ea;
         ea = (i % 2 == 0) ? FB + 32'(4 * (i / 2)) : RB + 32'(4 * (i / 2));
         total++;
         if (log_wr[0][i] !== (i % 2 == 1) || log_addr[0][i] !== ea || log_data[0][i] !== flash[0][i / 2]) begin
            bad++; $display("FAIL gap_xfer[%0d]: wr=%b addr=%h data=%h want %b %h %h", i,
                            log_wr[0][i], log_addr[0][i], log_data[0][i], (i % 2 == 1), ea, flash[0][i / 2]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (ram[0][i] !== flash[0][i]) begin
            bad++; $display("FAIL gap_ram[%0d]: got %h want %h", i, ram[0][i], flash[0][i]);
         end
      end
   endtask

   task automatic test_timing_b;
      int exp_pat [$];
      int cyc, got;
      for (int i = 0; i < 8; i++) begin ram[1][i] = '0; flash[1][i] = $urandom; end
      // Each word: read, write, then an idle cycle unless it was the last word.
      for (int i = 0; i < 2; i++) begin
         exp_pat.push_back(1);
         exp_pat.push_back(2);
         if (i < 1) exp_pat.push_back(0);
      end
      log_n[1] = 0;
      release_rst(1);
      cyc = 0;
      tick();
      while (b_rd[1] !== 1'b1 && cyc < 10) begin
         tick();
         cyc++;
      end
      total++;
      if (b_rd[1] !== 1'b1) begin
         bad++; $display("FAIL timing_b_start: no copy read seen, rd=%b", b_rd[1]);
      end
      for (int idx = 0; idx <= exp_pat.size(); idx++) begin
         if (idx > 0) tick();
         got = b_rd[1] ? 1 : (b_wr[1] ? 2 : 0);
         if (idx < exp_pat.size()) begin
            total++;
            if (got !== exp_pat[idx]) begin
               bad++; $display("FAIL timing_b_pattern[%0d]: got %0d want %0d", idx, got, exp_pat[idx]);
            end
         end
         total++;
         if (done[1] !== (idx >= exp_pat.size())) begin
            bad++; $display("FAIL timing_b_done[%0d]: got %b want %b", idx, done[1], (idx >= exp_pat.size()));
         end
      end
      total++;
      if (st[1] !== RUN) begin
         bad++; $display("FAIL timing_b_state: got %0d want %0d", st[1], RUN);
      end
      for (int i = 0; i < 2; i++) begin
         total++;
         if (ram[1][i] !== flash[1][i]) begin
            bad++; $display("FAIL timing_b_ram[%0d]: got %h want %h", i, ram[1][i], flash[1][i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] mdl [8];
      logic [31:0] a, d;
      bit          w;
      for (int i = 0; i < 8; i++) mdl[i] = (i < 2) ? flash[1][i] : 32'h0;
      for (int n = 0; n < 12; n++) begin
         a = 32'($urandom_range(0, 7)) << 2;
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         @(posedge clk);
         #1;
         c_rd[1] = !w; c_wr[1] = w; c_addr[1] = a; c_wdata[1] = d;
         tick();
         total++;
         if (b_rd[1] !== !w || b_wr[1] !== w || b_addr[1] !== a || b_wdata[1] !== d) begin
            bad++; $display("FAIL b2b_fwd[%0d]: rd=%b wr=%b addr=%h data=%h want %b %b %h %h", n,
                            b_rd[1], b_wr[1], b_addr[1], b_wdata[1], !w, w, a, d);
         end
         total++;
         if (c_ready[1] !== 1'b1 || c_rdata[1] !== b_rdata[1]) begin
            bad++; $display("FAIL b2b_ready[%0d]: ready=%b data=%h want 1 %h", n, c_ready[1], c_rdata[1], b_rdata[1]);
         end
         if (!w) begin
            total++;
            if (c_rdata[1] !== mdl[a[4:2]]) begin
               bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", n, c_rdata[1], mdl[a[4:2]]);
            end
         end else begin
            mdl[a[4:2]] = d;
         end
      end
      @(posedge clk);
      #1;
      c_rd[1] = 1'b0; c_wr[1] = 1'b0;
      tick();
      total++;
      if (c_ready[1] !== 1'b0 || b_rd[1] !== 1'b0 || b_wr[1] !== 1'b0) begin
         bad++; $display("FAIL b2b_idle: ready=%b rd=%b wr=%b want 0", c_ready[1], b_rd[1], b_wr[1]);
      end
   endtask

   task automatic test_bypass_c;
      logic [31:0] v;
      v = $urandom;
      ram[2][2] = v;
      log_n[2] = 0;
      release_rst(2);
      tick();
      total++;
      if (done[2] !== 1'b1 || st[2] !== RUN) begin
         bad++; $display("FAIL bypass_done: done=%b state=%0d want 1 %0d", done[2], st[2], RUN);
      end
      total++;
      if (b_rd[2] !== 1'b1 || b_addr[2] !== 32'h8) begin
         bad++; $display("FAIL bypass_fwd: rd=%b addr=%h want 1 00000008", b_rd[2], b_addr[2]);
      end
      total++;
      if (c_ready[2] !== 1'b1 || c_rdata[2] !== v) begin
         bad++; $display("FAIL bypass_read: ready=%b data=%h want 1 %h", c_ready[2], c_rdata[2], v);
      end
      @(posedge clk);
      #1 c_rd[2] = 1'b0;
      tick();
      total++;
      if (log_n[2] !== 1 || b_rd[2] !== 1'b0 || b_wr[2] !== 1'b0) begin
         bad++; $display("FAIL bypass_traffic: transfers=%0d rd=%b wr=%b want 1 0 0", log_n[2], b_rd[2], b_wr[2]);
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst_n[k] = 1'b0; c_rd[k] = 1'b0; c_wr[k] = 1'b0; c_addr[k] = '0; c_wdata[k] = '0;
         inject[k] = 1'b0;
         for (int i = 0; i < 8; i++) begin flash[k][i] = $urandom; ram[k][i] = '0; end
      end
      lat[0] = 2; lat[1] = 1; lat[2] = 1;
      // CPU requests held from before reset release; they must wait for RUN.
      c_rd[0] = 1'b1; c_addr[0] = 32'h4;
      c_rd[2] = 1'b1; c_addr[2] = 32'h8;

      test_reset();
      test_copy_a();
      test_mid_reset();
      test_gap_ready();
      test_timing_b();
      test_back_to_back();
      test_bypass_c();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
